// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the single-cycle processor blocks.
//   - opcode constants (instr[31:26])
//   - fetch-stage state encoding
//   - instruction width and a 16-bit immediate sign-extension helper
package proc_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ALU  = 6'd1;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_JMP  = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd13;
  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] sext16(input logic [15:0] v);
    return {{(INSTR_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_mem.sv
// instr_mem: 2^ADDR_W x 32 instruction store.
//   clk   - write clock
//   we    - write enable (synchronous)
//   waddr - write word address
//   wdata - write data
//   raddr - read word address (asynchronous read)
//   rdata - read data
// Contents are deliberately not reset so a loaded program survives rst.
module instr_mem
  import proc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, instruction memory, next-PC selection, run control and
// retired-instruction counter of the single-cycle processor.
//   clk, rst                - clock, async active-high reset
//   load_we/addr/data       - program load port (IDLE only)
//   start                   - begin / restart execution at PC 0
//   stall                   - hold PC, no retire this cycle
//   branch, jump, br_cond   - redirect controls
//   jump_target             - absolute jump word address
//   instr                   - current instruction (0 outside RUN)
//   pc, pc_plus1            - current PC and PC+1 (mod 2^ADDR_W)
//   instr_valid, halted     - RUN / HALT indicators
//   retired                 - saturating count of retired instructions
//
// state | meaning
// IDLE  | after reset; program may be loaded, waiting for start
// RUN   | fetching and retiring instructions
// HALT  | halt instruction retired; PC and counter frozen
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stall,
  input  logic               branch,
  input  logic               jump,
  input  logic               br_cond,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] br_sum;
  logic               mem_we;
  logic               halt_op;
  logic               unused_bits;

  // Loads are only accepted while idle so a running program cannot be
  // corrupted underneath the fetch.
  assign mem_we = load_we && (state_q == IDLE);

  instr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign halt_op  = (mem_rdata[31:26] == OP_HALT);
  // Branch target computed at full instruction width, then truncated so
  // the offset wraps modulo 2^ADDR_W.
  assign br_sum   = INSTR_W'(pc_plus1) + sext16(mem_rdata[15:0]);

  assign unused_bits = ^{mem_rdata[25:16], br_sum[INSTR_W-1:ADDR_W]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (start)                 state_d = RUN;
        else if (halt_op && !stall) state_d = HALT;
      end
      HALT: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // PC and retire counter
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    if (start) begin
      pc_d      = '0;
      retired_d = '0;
    end else if (state_q == RUN && !stall) begin
      if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
      // A retiring halt keeps the PC on itself, ignoring branch/jump.
      if (halt_op)                pc_d = pc_q;
      else if (jump)              pc_d = jump_target;
      else if (branch && br_cond) pc_d = br_sum[ADDR_W-1:0];
      else                        pc_d = pc_plus1;
    end
  end

  // Outputs
  always_comb begin
    instr       = '0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      RUN: begin
        instr       = mem_rdata;
        instr_valid = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign retired = retired_q;

endmodule
